// File: rtl/rpn_stack_issuer.sv
// RPN token issuer: turns operand/operator/end tokens into stack opcodes
// and reports one result and error code per expression.
module rpn_stack_issuer #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [1:0]       tok_kind,
    input  logic [WIDTH-1:0] tok_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_err,
    output logic [2:0]       stk_opcode,
    output logic [WIDTH-1:0] stk_data,
    input  logic [WIDTH-1:0] stk_output,
    input  logic             stk_empty,
    input  logic             stk_full,
    input  logic             stk_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CHECK,
        S_CAPTURE,
        S_DRAIN,
        S_RESULT
    } state_e;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [2:0] E_OK    = 3'd0;
    localparam logic [2:0] E_UNDER = 3'd1;
    localparam logic [2:0] E_FULL  = 3'd2;
    localparam logic [2:0] E_OVF   = 3'd3;
    localparam logic [2:0] E_END   = 3'd4;

    localparam logic [1:0] K_OPND = 2'd0;
    localparam logic [1:0] K_ADD  = 2'd1;
    localparam logic [1:0] K_MUL  = 2'd2;
    localparam logic [1:0] K_END  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       err_q, err_d;
    logic             end_seen_q, end_seen_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] sdata_q, sdata_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]       rerr_q, rerr_d;

    logic tok_fire;
    logic desync_full;
    logic desync_empty;

    // Once the end token is seen in DRAIN, hold off the next expression.
    assign tok_ready = (state_q == S_IDLE) |
                       ((state_q == S_DRAIN) & ~end_seen_q);
    assign tok_fire = tok_valid & tok_ready;

    assign desync_full  = stk_full & (count_q < CNT_MAX);
    assign desync_empty = ~stk_empty & (count_q == '0);

    assign stk_opcode = opcode_q;
    assign stk_data   = sdata_q;
    assign res_valid  = rvalid_q;
    assign res_data   = rdata_q;
    assign res_err    = rerr_q;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        count_d    = count_q;
        err_d      = err_q;
        end_seen_d = end_seen_q;
        opcode_d   = OP_NOP;
        sdata_d    = sdata_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rerr_d     = rerr_q;

        unique case (state_q)
            S_IDLE: begin
                if (tok_fire) begin
                    end_seen_d = (tok_kind == K_END);
                    if (desync_full) begin
                        err_d   = E_FULL;
                        state_d = S_DRAIN;
                    end else if (desync_empty) begin
                        err_d   = E_END;
                        state_d = S_DRAIN;
                    end else begin
                        unique case (tok_kind)
                            K_OPND: begin
                                if (count_q == CNT_MAX) begin
                                    err_d   = E_FULL;
                                    state_d = S_DRAIN;
                                end else begin
                                    opcode_d = OP_PUSH;
                                    sdata_d  = tok_data;
                                    count_d  = count_q + CNT_ONE;
                                    ret_d    = S_IDLE;
                                    state_d  = S_ISSUE;
                                end
                            end
                            K_ADD, K_MUL: begin
                                if (count_q >= CNT_TWO) begin
                                    opcode_d = (tok_kind == K_ADD) ?
                                               OP_ADD : OP_MUL;
                                    count_d  = count_q - CNT_ONE;
                                    ret_d    = S_CHECK;
                                    state_d  = S_ISSUE;
                                end else begin
                                    err_d   = E_UNDER;
                                    state_d = S_DRAIN;
                                end
                            end
                            K_END: begin
                                if (count_q == CNT_ONE) begin
                                    opcode_d = OP_POP;
                                    count_d  = '0;
                                    ret_d    = S_CAPTURE;
                                    state_d  = S_ISSUE;
                                end else begin
                                    err_d   = E_END;
                                    state_d = S_DRAIN;
                                end
                            end
                        endcase
                    end
                end
            end
            S_ISSUE: state_d = ret_q;
            S_CHECK: begin
                if (stk_overflow) begin
                    err_d      = E_OVF;
                    end_seen_d = 1'b0;
                    state_d    = S_DRAIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                rdata_d  = stk_output;
                rerr_d   = E_OK;
                rvalid_d = 1'b1;
                state_d  = S_RESULT;
            end
            S_DRAIN: begin
                if (count_q != '0) begin
                    opcode_d = OP_POP;
                    count_d  = count_q - CNT_ONE;
                end
                if (tok_fire && tok_kind == K_END) begin
                    end_seen_d = 1'b1;
                end
                if (count_q == '0 && end_seen_q) begin
                    rdata_d  = '0;
                    rerr_d   = err_q;
                    rvalid_d = 1'b1;
                    state_d  = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    rvalid_d   = 1'b0;
                    err_d      = E_OK;
                    end_seen_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            count_q    <= '0;
            err_q      <= E_OK;
            end_seen_q <= 1'b0;
            opcode_q   <= OP_NOP;
            sdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rerr_q     <= E_OK;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            count_q    <= count_d;
            err_q      <= err_d;
            end_seen_q <= end_seen_d;
            opcode_q   <= opcode_d;
            sdata_q    <= sdata_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rerr_q     <= rerr_d;
        end
    end

endmodule

// File: tb/tb_rpn_stack_issuer.sv
// Scoreboard bench for rpn_stack_issuer with a behavioural stack model.
module tb_rpn_stack_issuer;
    localparam int DEPTH = 256;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tok_valid = 1'b0;
    logic             tok_ready;
    logic [1:0]       tok_kind = 2'd0;
    logic [WIDTH-1:0] tok_data = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data;
    logic [2:0]       res_err;
    logic [2:0]       stk_opcode;
    logic [WIDTH-1:0] stk_data;
    logic [WIDTH-1:0] stk_output;
    logic             stk_empty;
    logic             stk_full;
    logic             stk_overflow;

    always #5 clk = ~clk;

    rpn_stack_issuer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_kind(tok_kind), .tok_data(tok_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err),
        .stk_opcode(stk_opcode), .stk_data(stk_data),
        .stk_output(stk_output), .stk_empty(stk_empty),
        .stk_full(stk_full), .stk_overflow(stk_overflow)
    );

    // Behavioural stack: samples opcode at posedge, outputs valid next cycle.
    logic [WIDTH-1:0] mem [DEPTH];
    int               sp;
    logic [WIDTH-1:0] m_out;
    logic             m_ovf;
    int               top_i, nxt_i;
    logic [WIDTH:0]   m_sum;
    logic [2*WIDTH-1:0] m_prod;
    int               n_push = 0, n_pop = 0, n_arith = 0;
    logic [11:0]      seq = '0;

    assign top_i  = (sp > 0) ? sp - 1 : 0;
    assign nxt_i  = (sp > 1) ? sp - 2 : 0;
    assign m_sum  = {1'b0, mem[top_i]} + {1'b0, mem[nxt_i]};
    assign m_prod = {{WIDTH{1'b0}}, mem[top_i]} * {{WIDTH{1'b0}}, mem[nxt_i]};
    assign stk_empty    = (sp == 0);
    assign stk_full     = (sp == DEPTH);
    assign stk_output   = m_out;
    assign stk_overflow = m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= 0;
            m_out <= '0;
            m_ovf <= 1'b0;
        end else begin
            case (stk_opcode)
                3'b110: if (sp < DEPTH) begin
                    mem[sp] <= stk_data;
                    sp <= sp + 1;
                end
                3'b111: if (sp > 0) begin
                    m_out <= mem[top_i];
                    sp <= sp - 1;
                end
                3'b100: if (sp > 1) begin
                    mem[nxt_i] <= m_sum[WIDTH-1:0];
                    m_out <= m_sum[WIDTH-1:0];
                    m_ovf <= m_sum[WIDTH];
                    sp <= sp - 1;
                end
                3'b101: if (sp > 1) begin
                    mem[nxt_i] <= m_prod[WIDTH-1:0];
                    m_out <= m_prod[WIDTH-1:0];
                    m_ovf <= |m_prod[2*WIDTH-1:WIDTH];
                    sp <= sp - 1;
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n && stk_opcode != 3'b000) begin
            seq <= {seq[8:0], stk_opcode};
            if (stk_opcode == 3'b110) n_push <= n_push + 1;
            if (stk_opcode == 3'b111) n_pop <= n_pop + 1;
            if (stk_opcode == 3'b100 || stk_opcode == 3'b101)
                n_arith <= n_arith + 1;
        end
    end

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [2:0]       err;
        int               npush;
        int               npop;
        int               narith;
        int               stall;
        logic             chk_seq;
        logic [11:0]      seq;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   held = 0;
    int   b_push = 0, b_pop = 0, b_arith = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: reset values while rst_n low, results against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
            res_ready = 1'b0;
            b_push = n_push;
            b_pop = n_pop;
            b_arith = n_arith;
            chk("rst_opcode", 64'(stk_opcode), 64'd0);
            chk("rst_stk_data", 64'(stk_data), 64'd0);
            chk("rst_res_valid", 64'(res_valid), 64'd0);
            chk("rst_res_data", 64'(res_data), 64'd0);
            chk("rst_res_err", 64'(res_err), 64'd0);
            chk("rst_tok_ready", 64'(tok_ready), 64'd1);
        end else if (res_valid) begin
            chk("tok_ready_in_result", 64'(tok_ready), 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
                res_ready = 1'b1;
            end else if (held < exp_q[0].stall) begin
                held++;
                res_ready = 1'b0;
            end else begin
                e = exp_q.pop_front();
                chk("res_data", 64'(res_data), 64'(e.data));
                chk("res_err", 64'(res_err), 64'(e.err));
                chk("pushes", 64'(n_push - b_push), 64'(e.npush));
                chk("pops", 64'(n_pop - b_pop), 64'(e.npop));
                chk("ariths", 64'(n_arith - b_arith), 64'(e.narith));
                chk("stack_empty", 64'(stk_empty), 64'd1);
                if (e.chk_seq) chk("op_seq", 64'(seq), 64'(e.seq));
                b_push = n_push;
                b_pop = n_pop;
                b_arith = n_arith;
                held = 0;
                res_ready = 1'b1;
            end
        end else begin
            res_ready = 1'b0;
        end
    end

    task automatic expect_res(input logic [WIDTH-1:0] d, input logic [2:0] er,
                              input int np, input int npop, input int nar,
                              input int stall, input logic cs,
                              input logic [11:0] sq);
        exp_t x;
        x.data = d; x.err = er; x.npush = np; x.npop = npop;
        x.narith = nar; x.stall = stall; x.chk_seq = cs; x.seq = sq;
        exp_q.push_back(x);
    endtask

    task automatic send(input logic [1:0] k, input logic [WIDTH-1:0] d);
        logic acc;
        @(negedge clk);
        tok_valid = 1'b1;
        tok_kind = k;
        tok_data = d;
        for (int n = 0; n < 3000; n++) begin
            acc = tok_ready;
            @(negedge clk);
            if (acc) begin
                tok_valid = 1'b0;
                return;
            end
        end
        $display("FAIL token_accept_timeout: got no accept, expected accept");
        $fatal(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        expect_res(32'd30, 3'd0, 2, 1, 1, 0, 1'b1, 12'hDA7);
        send(0, 32'd10); send(0, 32'd20); send(1, '0); send(3, '0);

        expect_res(32'd30, 3'd0, 2, 1, 1, 0, 1'b0, '0);
        send(0, 32'd5); send(0, 32'd6); send(2, '0); send(3, '0);

        expect_res(32'd30, 3'd0, 2, 1, 1, 5, 1'b0, '0);
        send(0, 32'd5); send(0, 32'd6); send(2, '0); send(3, '0);

        expect_res(32'd0, 3'd3, 2, 1, 1, 0, 1'b0, '0);
        send(0, 32'hFFFF_FFFF); send(0, 32'd1); send(1, '0); send(3, '0);

        expect_res(32'd0, 3'd2, 256, 256, 0, 0, 1'b0, '0);
        for (int i = 1; i <= 257; i++) send(0, 32'(i));
        send(3, '0);

        expect_res(32'd0, 3'd1, 1, 1, 0, 0, 1'b0, '0);
        send(0, 32'd7); send(1, '0); send(0, 32'd3); send(3, '0);

        expect_res(32'd0, 3'd4, 2, 2, 0, 0, 1'b0, '0);
        send(0, 32'd1); send(0, 32'd2); send(3, '0);

        expect_res(32'd0, 3'd4, 0, 0, 0, 0, 1'b0, '0);
        send(3, '0);

        // 100 pushes then a malformed end: DRAIN starts with count=100.
        for (int i = 0; i < 100; i++) send(0, 32'(i));
        send(3, '0);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        expect_res(32'd16, 3'd0, 2, 1, 1, 0, 1'b0, '0);
        send(0, 32'd4); send(0, 32'd4); send(2, '0); send(3, '0);

        for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL result_timeout: got %0d pending, expected 0",
                     exp_q.size());
            $fatal(1);
        end
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpn_stack_issuer.md
Name: rpn_stack_issuer

Overview:
- Command initiator for the `stack` block. Accepts a stream of RPN expression tokens (operands and operators) over a valid/ready handshake.
- Translates each token into the stack opcode protocol (push/pop/add/mul) and returns one result plus error code per expression.
- Sits between a token source and a single `stack` instance. It is the only master of that stack's opcode port.

Parameters:
- DEPTH, 256, capacity of the attached stack. Used for the shadow occupancy count.
- WIDTH, 32, data width of operands, stack and result.
- CNT_W, $clog2(DEPTH+1), width of the shadow occupancy counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tok_valid  in  1  token present
- tok_ready  out  1  issuer accepts token this cycle
- tok_kind  in  2  0=operand, 1=add, 2=mul, 3=end-of-expression
- tok_data  in  WIDTH  operand value (ignored unless tok_kind=0)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  expression value (0 on error)
- res_err  out  3  0=ok, 1=operand underflow, 2=stack full, 3=arith overflow, 4=malformed end
- stk_opcode  out  3  000 nop, 100 add, 101 mul, 110 push, 111 pop
- stk_data  out  WIDTH  push data to stack
- stk_output  in  WIDTH  stack output_data
- stk_empty  in  1  stack empty
- stk_full  in  1  stack full
- stk_overflow  in  1  stack overflow flag from last add/mul

Behaviour:
- Stack contract:
  - Stack samples stk_opcode/stk_data at a rising edge.
  - stk_output/stk_overflow reflect that op from the following cycle.
  - add/mul pop two and push one.
- Registered outputs:
  - stk_opcode, stk_data, res_* are registered.
  - tok_ready is decoded from state (1 only in IDLE and DRAIN).
- Reset (async, rst_n=0):
  - state=IDLE, count=0, stk_opcode=000, stk_data=0, res_valid=0, res_data=0, res_err=0, pending error=0.
  - Reset mid-expression abandons it. No drain is issued; the stack is reset by the same rst_n.
- stk_opcode is 000 in every cycle not listed below. Every non-nop opcode lasts exactly one cycle.
- IDLE, token accepted (tok_valid & tok_ready):
  - operand, count<DEPTH: next cycle stk_opcode=110, stk_data=tok_data, count+1 -> ISSUE (1 cycle) -> IDLE. Throughput is 1 operand per 2 cycles.
  - operand, count==DEPTH: err=2 -> DRAIN. No push is issued.
  - add/mul, count>=2: next cycle stk_opcode=100/101, count-1 -> ISSUE -> CHECK.
  - add/mul, count<2: err=1 -> DRAIN.
  - end, count==1: next cycle stk_opcode=111, count=0 -> ISSUE -> CAPTURE.
  - end, count!=1: err=4 -> DRAIN, marked end-seen.
- CHECK (opcode nop): if stk_overflow=1 then err=3 -> DRAIN, else -> IDLE.
- CAPTURE: res_data<=stk_output, res_err<=0, res_valid<=1 -> RESULT.
- DRAIN:
  - Issue 111 every cycle while count>0, decrementing count.
  - Simultaneously accept and discard tokens until an end token (unless already end-seen).
  - Exit when count==0 and end-seen: res_data=0, res_err=err, res_valid=1 -> RESULT.
- RESULT: hold res_valid/res_data/res_err until res_ready=1. Then res_valid<=0 -> IDLE. No tokens are accepted while in RESULT.
- stk_full=1 while count<DEPTH, or stk_empty=0 when count==0 in IDLE: protocol desync. Latch err=2 (full) / 4 (empty) on the next token and DRAIN. count remains the authority for pops.
- Arithmetic: no width changes in the issuer. Overflow detection is solely via stk_overflow.

Test Plan:
- Push 10, push 20, add, end -> stk_opcode seq 110,110,100,111; res_data=30, res_err=0; count returns to 0.
- Push 5, push 6, mul, end -> res_data=30, res_err=0. Repeat with res_ready held low 5 cycles -> res_valid held, tok_ready=0 throughout, result then accepted.
- Push 32'hFFFFFFFF, push 1, add, end -> CHECK sees stk_overflow=1; one drain pop issued; res_err=3, res_data=0.
- DEPTH=256: push 1..257, end -> 256 pushes issued, 257th rejected; 256 pops in DRAIN; stk_empty=1 at finish; res_err=2.
- Push 7, add, push 3, end -> res_err=1; add never issued; trailing tokens discarded; 1 pop issued. Push 1, push 2, end -> res_err=4, 2 pops issued. Lone end -> res_err=4, 0 pops.
- Assert rst_n=0 during DRAIN with count=100 -> outputs immediately at reset values, state IDLE, tok_ready=1 after release; next expression 4,4,mul,end -> 16.
